// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the instruction-fetch path: fetch states, buffered
// fetch entries and the word-alignment helper.
package fetch_sequencer_pkg;

   typedef logic [31:0] UWord;

   typedef enum logic [1:0] {
      FETCH      = 2'd0,
      HALT_DRAIN = 2'd1,
      HALTED     = 2'd2
   } FetchState;

   typedef struct packed {
      UWord instr;
      UWord pc;
   } FetchEntry;

   // Canonical ADDI x0,x0,0; upstream stages insert it when they squash slots.
   localparam UWord NOP = 32'h0000_0013;

   function automatic UWord align_word(input UWord addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel plus
// the valid/ready instruction stream towards decode.
interface fetch_sequencer_if;
   import fetch_sequencer_pkg::*;

   logic imem_req;
   UWord imem_addr;
   logic imem_gnt;
   logic imem_rvalid;
   UWord imem_rdata;

   logic if_valid;
   UWord if_instr;
   UWord if_pc;
   logic id_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata,
      output if_valid,
      output if_instr,
      output if_pc,
      input  id_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata,
      input  if_valid,
      input  if_instr,
      input  if_pc,
      output id_ready
   );

endinterface

// File: rtl/fetch_sequencer_fifo.sv
// Small FIFO of {instr, pc} entries with a combinational head; a flush
// empties it and wins over a push in the same cycle.
module fetch_fifo
   import fetch_sequencer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  FetchEntry              push_data,
   input  logic                   pop,
   input  logic                   flush,
   output FetchEntry              head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   FetchEntry        mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && !full;
   assign head    = mem_reg[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage needs no reset: a slot is only visible after it has been written.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_reg[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: issues word fetches, buffers responses for decode,
// handles redirects/halt. Optional macro FETCH_BYPASS_EN adds a same-cycle response bypass.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              clk,
   input  logic              reset_n,
   fetch_sequencer_if.master bus,
   input  logic              redirect_valid,
   input  UWord              redirect_pc,
   input  logic              halt,
   output logic              halted
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   FetchState        state_reg, state_next;
   UWord             pc_reg, pc_next;
   UWord             rsp_pc_reg, rsp_pc_next;
   logic [CNT_W-1:0] inflight_reg, inflight_next;
   logic [CNT_W-1:0] discard_reg, discard_next;
   logic             active_reg;
   FetchEntry        hold_reg;

   logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   FetchEntry        fifo_head, resp_entry, out_entry;
   logic             grant, resp, resp_keep, bypass, out_valid;
   logic [CNT_W:0]   occupancy;

   assign resp       = bus.imem_rvalid && (inflight_reg != '0);
   assign occupancy  = {1'b0, inflight_reg} + {1'b0, fifo_count};
   assign resp_entry = '{instr: bus.imem_rdata, pc: rsp_pc_reg};

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      rsp_pc_next   = rsp_pc_reg;
      inflight_next = inflight_reg;
      discard_next  = discard_reg;
      fifo_flush    = 1'b0;
      resp_keep     = 1'b0;
      bus.imem_req  = 1'b0;
      grant         = 1'b0;

      case (state_reg)
         FETCH: begin
            if (halt) begin
               state_next = HALT_DRAIN;
               fifo_flush = 1'b1;
            end else if (redirect_valid) begin
               fifo_flush  = 1'b1;
               pc_next     = align_word(redirect_pc);
               rsp_pc_next = align_word(redirect_pc);
            end else begin
               bus.imem_req = active_reg && (occupancy < (CNT_W+1)'(DEPTH));
               resp_keep    = resp && (discard_reg == '0);
            end
         end
         HALT_DRAIN: ;
         HALTED:     ;
         default:    state_next = FETCH;
      endcase

      grant         = bus.imem_req && bus.imem_gnt;
      inflight_next = inflight_reg + CNT_W'(grant) - CNT_W'(resp);
      if (grant)     pc_next     = pc_reg + 32'd4;
      if (resp_keep) rsp_pc_next = rsp_pc_reg + 32'd4;

      // Everything still outstanding after this cycle belongs to the old path.
      if (fifo_flush)
         discard_next = inflight_next;
      else if (resp && (discard_reg != '0))
         discard_next = discard_reg - CNT_W'(1);

      if ((state_reg == HALT_DRAIN) && (inflight_next == '0))
         state_next = HALTED;
   end

`ifdef FETCH_BYPASS_EN
   assign bypass    = resp_keep && fifo_empty;
   assign fifo_push = resp_keep && !fifo_full && !(bypass && bus.id_ready);
`else
   assign bypass    = 1'b0;
   assign fifo_push = resp_keep && !fifo_full;
`endif

   always_comb begin
      out_valid = !fifo_empty;
      out_entry = fifo_head;
      if (bypass) begin
         out_valid = 1'b1;
         out_entry = resp_entry;
      end
   end

   assign fifo_pop      = out_valid && bus.id_ready && !fifo_empty;
   assign bus.if_valid  = out_valid;
   assign bus.if_instr  = out_valid ? out_entry.instr : hold_reg.instr;
   assign bus.if_pc     = out_valid ? out_entry.pc    : hold_reg.pc;
   assign bus.imem_addr = pc_reg;
   assign halted        = (state_reg == HALTED);

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (resp_entry),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // active_reg holds off the first request until one edge after reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= FETCH;
         pc_reg       <= RESET_PC;
         rsp_pc_reg   <= RESET_PC;
         inflight_reg <= '0;
         discard_reg  <= '0;
         active_reg   <= 1'b0;
         hold_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         rsp_pc_reg   <= rsp_pc_next;
         inflight_reg <= inflight_next;
         discard_reg  <= discard_next;
         active_reg   <= 1'b1;
         if (out_valid) hold_reg <= out_entry;
      end
   end

endmodule
